game_state_fsm: RTL and testbench

- Top-level game sequencer that drives fish_controller's one-hot phase inputs: q_start_menu, q_base_play, q_line_reel, q_game_finish.
- Consumes fish_controller's fish_hooked / fish_caught_lost handshake, the start/quit buttons and a round countdown timer.
- Clocked on the same game clk as fish_controller, upstream of it; time_left also feeds the seven-segment display path.

---
 rtl/fish_game_pkg.sv | 15 +
 rtl/rising_edge_detect.sv | 23 ++
 rtl/game_state_fsm.sv | 144 ++++++++++++++
 tb/tb_game_state_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fish_game_pkg.sv
// Shared types and defaults for the fish game sequencer.
package fish_game_pkg;

    typedef enum logic [1:0] {
        START_MENU  = 2'd0,
        BASE_PLAY   = 2'd1,
        LINE_REEL   = 2'd2,
        GAME_FINISH = 2'd3
    } game_state_e;

    localparam int unsigned SCORE_W               = 16;
    localparam int unsigned DEFAULT_GAME_SECONDS  = 60;
    localparam int unsigned DEFAULT_TICKS_PER_SEC = 50;

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector with a configurable reset value for the previous-sample register.
module rising_edge_detect #(
    parameter bit PrevRst = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= PrevRst;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_state_fsm.sv
// Top-level game sequencer: one-hot phase outputs, round countdown and optional best score.
// Optional feature: define HIGH_SCORE_EN to track the best score across rounds.
module game_state_fsm
    import fish_game_pkg::*;
#(
    parameter int unsigned GAME_SECONDS  = DEFAULT_GAME_SECONDS,
    parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int unsigned TW            = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               quit,
    input  logic               fish_hooked,
    input  logic               fish_caught_lost,
    input  logic [SCORE_W-1:0] score,
    output logic               q_start_menu,
    output logic               q_base_play,
    output logic               q_line_reel,
    output logic               q_game_finish,
    output logic [TW-1:0]      time_left,
    output logic [SCORE_W-1:0] high_score
);

    localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0]    GameSecs = TW'(GAME_SECONDS);

    game_state_e       state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [TW-1:0]     time_q, time_d;
    logic              start_rise, quit_rise;
    logic              tick_last, timeout;

    // Prev registers reset high so a button held through reset yields no edge.
    rising_edge_detect #(
        .PrevRst (1'b1)
    ) u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (start),
        .rise_o (start_rise)
    );

    rising_edge_detect #(
        .PrevRst (1'b1)
    ) u_quit_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (quit),
        .rise_o (quit_rise)
    );

    assign tick_last = (tick_q == TickLast);
    assign timeout   = (tick_last && (time_q == TW'(1))) || (time_q == '0);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        time_d  = time_q;
        unique case (state_q)
            START_MENU: begin
                if (start_rise) begin
                    state_d = BASE_PLAY;
                    time_d  = GameSecs;
                    tick_d  = '0;
                end
            end
            BASE_PLAY: begin
                if (tick_last) begin
                    tick_d = '0;
                    time_d = (time_q == '0) ? '0 : time_q - TW'(1);
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
                if (quit_rise || timeout) begin
                    state_d = GAME_FINISH;
                end else if (fish_hooked) begin
                    state_d = LINE_REEL;
                end
            end
            LINE_REEL: begin
                // Timer frozen so a hooked fish always resolves; hooked wins a clash.
                if (quit_rise) begin
                    state_d = GAME_FINISH;
                end else if (fish_caught_lost && !fish_hooked) begin
                    state_d = BASE_PLAY;
                end
            end
            GAME_FINISH: begin
                if (start_rise) begin
                    state_d = START_MENU;
                    time_d  = GameSecs;
                end
            end
            default: state_d = START_MENU;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= START_MENU;
            tick_q  <= '0;
            time_q  <= GameSecs;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            time_q  <= time_d;
        end
    end

    assign q_start_menu  = (state_q == START_MENU);
    assign q_base_play   = (state_q == BASE_PLAY);
    assign q_line_reel   = (state_q == LINE_REEL);
    assign q_game_finish = (state_q == GAME_FINISH);
    assign time_left     = time_q;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] hs_q, hs_d;

    // Score is sampled on the edge that enters GAME_FINISH.
    always_comb begin
        hs_d = hs_q;
        if ((state_d == GAME_FINISH) && (state_q != GAME_FINISH) && (score > hs_q)) begin
            hs_d = score;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q <= '0;
        end else begin
            hs_q <= hs_d;
        end
    end

    assign high_score = hs_q;
`else
    logic unused_score;
    assign unused_score = ^score;
    assign high_score   = '0;
`endif

endmodule

// File: tb/tb_game_state_fsm.sv
// Scoreboard bench for game_state_fsm with GAME_SECONDS=3, TICKS_PER_SEC=4.
module tb_game_state_fsm;

    localparam logic [3:0] PhMenu = 4'b0001;
    localparam logic [3:0] PhBase = 4'b0010;
    localparam logic [3:0] PhReel = 4'b0100;
    localparam logic [3:0] PhFin  = 4'b1000;
`ifdef HIGH_SCORE_EN
    localparam bit HsEn = 1'b1;
`else
    localparam bit HsEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        quit;
    logic        fish_hooked;
    logic        fish_caught_lost;
    logic [15:0] score;
    logic        q_start_menu;
    logic        q_base_play;
    logic        q_line_reel;
    logic        q_game_finish;
    logic [7:0]  time_left;
    logic [15:0] high_score;

    game_state_fsm #(
        .GAME_SECONDS  (3),
        .TICKS_PER_SEC (4),
        .TW            (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .quit             (quit),
        .fish_hooked      (fish_hooked),
        .fish_caught_lost (fish_caught_lost),
        .score            (score),
        .q_start_menu     (q_start_menu),
        .q_base_play      (q_base_play),
        .q_line_reel      (q_line_reel),
        .q_game_finish    (q_game_finish),
        .time_left        (time_left),
        .high_score       (high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       nm_q[$];
    logic [3:0]  ph_q[$];
    logic [7:0]  tl_q[$];
    logic [15:0] hs_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] hs_exp   = 16'd0;
    event        sample_ev;

    task automatic push_exp(input string nm, input logic [3:0] ph, input int tl);
        nm_q.push_back(nm);
        ph_q.push_back(ph);
        tl_q.push_back(tl[7:0]);
        hs_q.push_back(hs_exp);
    endtask

    // Advance one clock edge and expect the given outputs after it.
    task automatic step(input string nm, input logic [3:0] ph, input int tl);
        @(posedge clk);
        #1;
        push_exp(nm, ph, tl);
    endtask

    task automatic hs_on_finish(input int unsigned s);
        if (HsEn && (s > hs_exp)) hs_exp = s[15:0];
    endtask

    // Monitor: checks one-hot every sample and pops one expectation when available.
    initial begin
        string       nm;
        logic [3:0]  ph, act;
        logic [7:0]  tl;
        logic [15:0] hs;
        forever begin
            @(negedge clk or sample_ev);
            act = {q_game_finish, q_line_reel, q_base_play, q_start_menu};
            n_checks++;
            if (!$onehot(act)) begin
                n_fail++;
                $display("FAIL onehot: got phase=%b, required exactly one bit set", act);
            end
            if (nm_q.size() > 0) begin
                nm = nm_q.pop_front();
                ph = ph_q.pop_front();
                tl = tl_q.pop_front();
                hs = hs_q.pop_front();
                n_checks++;
                if (act !== ph || time_left !== tl || high_score !== hs) begin
                    n_fail++;
                    $display("FAIL %s: got phase=%b time_left=%0d high_score=%0d, required phase=%b time_left=%0d high_score=%0d",
                             nm, act, time_left, high_score, ph, tl, hs);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b1; quit = 1'b0;
        fish_hooked = 1'b0; fish_caught_lost = 1'b0; score = 16'd0;
        #1 rst = 1'b0;
        #1 push_exp("reset", PhMenu, 3);
        @(posedge clk); #1 rst = 1'b1;

        // Start held through reset: no edge.
        for (int i = 0; i < 3; i++) step("start held", PhMenu, 3);
        start = 1'b0;
        step("start released", PhMenu, 3);
        start = 1'b1; score = 16'd150;
        step("start press", PhBase, 3);
        start = 1'b0;

        // Round 1: free-running countdown to timeout on the 12th edge.
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) begin
                hs_on_finish(150);
                step("timeout", PhFin, 0);
            end else begin
                step("countdown", PhBase, 3 - k / 4);
            end
        end
        step("finish hold", PhFin, 0);
        step("finish hold", PhFin, 0);
        start = 1'b1;
        step("restart to menu", PhMenu, 3);
        start = 1'b0; score = 16'd75;
        step("menu idle", PhMenu, 3);
        start = 1'b1;
        step("round 2 start", PhBase, 3);
        start = 1'b0;

        // Round 2: hook at time_left=2, tick=1, then resume.
        step("r2 count", PhBase, 3);
        step("r2 count", PhBase, 3);
        step("r2 count", PhBase, 3);
        step("r2 count", PhBase, 2);
        step("r2 count", PhBase, 2);
        fish_hooked = 1'b1;
        step("hooked", PhReel, 2);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) fish_caught_lost = 1'b1;
            step("reel frozen", PhReel, 2);
        end
        fish_hooked = 1'b0;
        step("fish resolved", PhBase, 2);
        fish_caught_lost = 1'b0;
        step("tick resume", PhBase, 2);
        step("tick resume drop", PhBase, 1);

        // Quit beats a simultaneous hook; held quit gives one transition.
        quit = 1'b1; fish_hooked = 1'b1;
        hs_on_finish(75);
        step("quit over hook", PhFin, 1);
        fish_hooked = 1'b0;
        for (int i = 0; i < 10; i++) step("quit held", PhFin, 1);
        start = 1'b1;
        step("menu via start", PhMenu, 3);
        start = 1'b0; score = 16'd300;
        step("menu quit ignored", PhMenu, 3);
        start = 1'b1;
        step("round 3 start", PhBase, 3);
        start = 1'b0;
        step("quit still held", PhBase, 3);
        step("quit still held", PhBase, 3);
        step("quit still held", PhBase, 3);
        step("quit still held", PhBase, 2);
        quit = 1'b0;
        step("quit released", PhBase, 2);
        quit = 1'b1;
        hs_on_finish(300);
        step("quit press", PhFin, 2);
        quit = 1'b0;

        // Round 4: async reset in the middle of LINE_REEL.
        start = 1'b1;
        step("r4 menu", PhMenu, 3);
        start = 1'b0;
        step("r4 menu idle", PhMenu, 3);
        start = 1'b1;
        step("r4 start", PhBase, 3);
        start = 1'b0; fish_hooked = 1'b1;
        step("r4 hooked", PhReel, 3);
        @(negedge clk);
        #1 rst = 1'b0;
        hs_exp = 16'd0;
        #1 push_exp("async reset", PhMenu, 3);
        -> sample_ev;
        @(posedge clk); #1;
        rst = 1'b1; fish_hooked = 1'b0;
        step("post reset idle", PhMenu, 3);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (nm_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, required 0", nm_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
